ram_fifo_ctrl: RTL and testbench

//  Single-clock FIFO controller directly upstream of the 32x4 single-port RAM (ram).

---
 rtl/ram_fifo_pkg.sv | 13 +
 rtl/ram_fifo_if.sv | 20 ++
 rtl/ram.sv | 14 +
 rtl/ram_fifo_ptr.sv | 13 +
 rtl/ram_fifo_ctrl.sv | 46 ++++
 tb/tb_ram_fifo_ctrl.sv | 156 +++++++++++++++
 6 files changed

// File: rtl/ram_fifo_pkg.sv
// ram_fifo_pkg: shared widths and types for ram and ram_fifo_ctrl
package ram_fifo_pkg;
  localparam int DW = 4;
  localparam int AW = 5;
  localparam int DEPTH = 1 << AW;
  localparam int AF_LEVEL = 28;
  localparam int AE_LEVEL = 4;
  localparam int RAM_DW = DW;
  localparam int RAM_AW = AW;
  typedef logic [DW-1:0] data_t;
  typedef logic [AW-1:0] addr_t;
  typedef logic [AW:0] cnt_t;
endpackage

// File: rtl/ram_fifo_if.sv
// ram_fifo_if: write stream, read stream, RAM port and occupancy (almost flags with RAM_FIFO_ALMOST_EN)
interface ram_fifo_if;
  import ram_fifo_pkg::*;
  logic in_valid, in_ready, dout_valid, dout_ready, ram_we;
  data_t in_data, dout_data, ram_di, ram_do;
  addr_t ram_a;
  cnt_t count;
`ifdef RAM_FIFO_ALMOST_EN
  logic almost_full, almost_empty;
  modport slave (input in_valid, in_data, dout_ready, ram_do,
                 output in_ready, dout_valid, dout_data, ram_we, ram_a, ram_di, count, almost_full, almost_empty);
  modport master (output in_valid, in_data, dout_ready, ram_do,
                  input in_ready, dout_valid, dout_data, ram_we, ram_a, ram_di, count, almost_full, almost_empty);
`else
  modport slave (input in_valid, in_data, dout_ready, ram_do,
                 output in_ready, dout_valid, dout_data, ram_we, ram_a, ram_di, count);
  modport master (output in_valid, in_data, dout_ready, ram_do,
                  input in_ready, dout_valid, dout_data, ram_we, ram_a, ram_di, count);
`endif
endinterface

// File: rtl/ram.sv
// ram: 32x4 single-port RAM, synchronous write, combinational read
module ram
  import ram_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [RAM_AW-1:0] a,
  input  logic [RAM_DW-1:0] di,
  output logic [RAM_DW-1:0] dataout
);
  logic [RAM_DW-1:0] mem [1<<RAM_AW];
  always_ff @(posedge clk) if (we) mem[a] <= di;
  assign dataout = mem[a];
endmodule

// File: rtl/ram_fifo_ptr.sv
// ram_fifo_ptr: wrap-around RAM address pointer
module ram_fifo_ptr
  import ram_fifo_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  inc,
  output addr_t ptr
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (inc) ptr <= ptr + addr_t'(1);
endmodule

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: single-port RAM FIFO controller, read-priority arbitration; almost flags with RAM_FIFO_ALMOST_EN
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
(
  input logic       clk,
  input logic       rst_n,
  ram_fifo_if.slave bus
);
  addr_t wr_ptr, rd_ptr;
  cnt_t count_q, count_next;
  logic rd_slot, wr;
  always_comb begin
    rd_slot = (count_q != '0) && (!bus.dout_valid || bus.dout_ready);
    bus.in_ready = rst_n && !rd_slot && (count_q != cnt_t'(DEPTH));
    wr = bus.in_valid && bus.in_ready;
    bus.ram_we = wr;
    bus.ram_a = rd_slot ? rd_ptr : wr_ptr;
    bus.ram_di = bus.in_data;
    count_next = count_q + cnt_t'(wr) - cnt_t'(rd_slot);
  end
  assign bus.count = count_q;
  ram_fifo_ptr u_wr (.clk(clk), .rst_n(rst_n), .inc(wr), .ptr(wr_ptr));
  ram_fifo_ptr u_rd (.clk(clk), .rst_n(rst_n), .inc(rd_slot), .ptr(rd_ptr));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count_q <= '0;
      bus.dout_valid <= 1'b0;
      bus.dout_data <= '0;
    end else begin
      count_q <= count_next;
      if (rd_slot) begin
        bus.dout_data <= bus.ram_do;
        bus.dout_valid <= 1'b1;
      end else if (bus.dout_ready) bus.dout_valid <= 1'b0;
    end
`ifdef RAM_FIFO_ALMOST_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.almost_full <= 1'b0;
      bus.almost_empty <= 1'b1;
    end else begin
      bus.almost_full <= count_next >= cnt_t'(AF_LEVEL);
      bus.almost_empty <= count_next <= cnt_t'(AE_LEVEL);
    end
`endif
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: directed vectors plus queue-checked fill, wrap and reset sequences
module tb_ram_fifo_ctrl;
  import ram_fifo_pkg::*;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  ram_fifo_if bus ();
  ram_fifo_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  ram u_ram (.clk(clk), .we(bus.ram_we), .a(bus.ram_a), .di(bus.ram_di), .dataout(bus.ram_do));
  int total = 0, bad = 0;
  data_t q[$];
  addr_t wa;
  logic acc;
  typedef struct {
    logic iv; data_t d; logic dr;
    logic ir; logic we; addr_t a; logic dv; data_t dd; cnt_t cnt;
  } vec_t;
  vec_t tv[9];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask
  task automatic step();
    data_t e;
    #1;
    acc = 0;
    chk("count", 32'(bus.count), 32'(q.size()) - 32'(bus.dout_valid));
    if (bus.count != 0 && (!bus.dout_valid || bus.dout_ready))
      chk("rd_blocks_wr", 32'({bus.in_ready, bus.ram_we}), 0);
    if (bus.ram_we) begin
      chk("wr_addr", 32'(bus.ram_a), 32'(wa));
      chk("wr_data", 32'(bus.ram_di), 32'(bus.in_data));
    end
    if (bus.in_valid && bus.in_ready) begin
      q.push_back(bus.in_data);
      wa++;
      acc = 1;
    end
    if (bus.dout_valid && bus.dout_ready) begin
      if (q.size() == 0) chk("underflow", 1, 0);
      else begin
        e = q.pop_front();
        chk("order", 32'(bus.dout_data), 32'(e));
      end
    end
    @(negedge clk);
  endtask
  task automatic send(input data_t d);
    bus.in_valid = 1;
    bus.in_data = d;
    for (int i = 0; i < 8; i++) begin
      step();
      if (acc) break;
    end
    if (!acc) chk("send_timeout", 0, 1);
    bus.in_valid = 0;
  endtask
  task automatic drain();
    bus.dout_ready = 1;
    for (int i = 0; i < 200 && q.size() != 0; i++) step();
    chk("drained", 32'(q.size()), 0);
    step();
    chk("empty_dv", 32'(bus.dout_valid), 0);
    chk("empty_cnt", 32'(bus.count), 0);
  endtask
  initial begin
    bus.in_valid = 1;
    bus.in_data = 5;
    bus.dout_ready = 0;
    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_we", 32'(bus.ram_we), 0);
    chk("rst_dv", 32'(bus.dout_valid), 0);
    chk("rst_cnt", 32'(bus.count), 0);
    chk("rst_dd", 32'(bus.dout_data), 0);
`ifdef RAM_FIFO_ALMOST_EN
    chk("rst_ae", 32'(bus.almost_empty), 1);
    chk("rst_af", 32'(bus.almost_full), 0);
`endif
    @(negedge clk);
    bus.in_valid = 0;
    rst_n = 1;
    tv[0] = '{1, 4, 0, 1, 1, 0, 0, 0, 0};
    tv[1] = '{1, 8, 0, 0, 0, 0, 0, 0, 1};
    tv[2] = '{1, 8, 0, 1, 1, 1, 1, 4, 0};
    tv[3] = '{1, 2, 0, 1, 1, 2, 1, 4, 1};
    tv[4] = '{0, 0, 0, 1, 0, 3, 1, 4, 2};
    tv[5] = '{0, 0, 1, 0, 0, 1, 1, 4, 2};
    tv[6] = '{0, 0, 1, 0, 0, 2, 1, 8, 1};
    tv[7] = '{0, 0, 1, 1, 0, 3, 1, 2, 0};
    tv[8] = '{0, 0, 1, 1, 0, 3, 0, 2, 0};
    for (int i = 0; i < 9; i++) begin
      bus.in_valid = tv[i].iv;
      bus.in_data = tv[i].d;
      bus.dout_ready = tv[i].dr;
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'(tv[i].ir));
      chk($sformatf("v%0d_we", i), 32'(bus.ram_we), 32'(tv[i].we));
      chk($sformatf("v%0d_a", i), 32'(bus.ram_a), 32'(tv[i].a));
      chk($sformatf("v%0d_dv", i), 32'(bus.dout_valid), 32'(tv[i].dv));
      if (tv[i].dv) chk($sformatf("v%0d_dd", i), 32'(bus.dout_data), 32'(tv[i].dd));
      chk($sformatf("v%0d_cnt", i), 32'(bus.count), 32'(tv[i].cnt));
      @(negedge clk);
    end
    bus.in_valid = 0;
    bus.dout_ready = 0;
    wa = 3;
    for (int i = 0; i < 33; i++) send(data_t'((i * 5 + 1) % 16));
    chk("full_cnt", 32'(bus.count), 32);
    chk("full_in_ready", 32'(bus.in_ready), 0);
    chk("full_dv", 32'(bus.dout_valid), 1);
    chk("full_dd", 32'(bus.dout_data), 1);
`ifdef RAM_FIFO_ALMOST_EN
    chk("full_af", 32'(bus.almost_full), 1);
`endif
    bus.in_valid = 1;
    bus.in_data = 4'hF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("full_no_we", 32'(bus.ram_we), 0);
      chk("full_no_ready", 32'(bus.in_ready), 0);
      @(negedge clk);
    end
    bus.in_valid = 0;
    drain();
    bus.dout_ready = 1;
    for (int i = 0; i < 40; i++) send(data_t'((i * 3 + 7) % 16));
    drain();
    bus.dout_ready = 0;
    for (int i = 0; i < 6; i++) send(data_t'(i + 2));
    chk("pre_rst_cnt", 32'(bus.count), 5);
    bus.in_valid = 1;
    bus.in_data = 4'h9;
    #3;
    rst_n = 0;
    #1;
    chk("mid_rst_cnt", 32'(bus.count), 0);
    chk("mid_rst_dv", 32'(bus.dout_valid), 0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 0);
    chk("mid_rst_we", 32'(bus.ram_we), 0);
    q.delete();
    wa = 0;
    @(negedge clk);
    bus.in_valid = 0;
    rst_n = 1;
    send(4'hA);
    step();
    chk("post_rst_dv", 32'(bus.dout_valid), 1);
    chk("post_rst_dd", 32'(bus.dout_data), 32'hA);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
